// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead add/subtract unit with valid/ready flow control.
// Stage 1 registers bit and group propagate/generate terms; stage 2 resolves carries and registers the result.
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    logic [WIDTH-1:0] bb_s;
    logic [WIDTH-1:0] p_d, g_d, p_q, g_q;
    logic [NG-1:0]    gp_d, gg_d, gp_q, gg_q;
    logic             c0_d, c0_q;
    logic             v1_d, v1_q, v2_d, v2_q;
    logic             adv1_s, adv2_s;
    logic [NG:0]      cg_s;
    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q;

    // Handshake: in_ready depends only on pipeline occupancy and out_ready.
    always_comb begin
        adv2_s   = v1_q & (~v2_q | out_ready);
        in_ready = ~v1_q | adv2_s;
        adv1_s   = in_valid & in_ready;
        v1_d     = adv1_s | (v1_q & ~adv2_s);
        v2_d     = adv2_s | (v2_q & ~out_ready);
    end

    // Stage 1 combinational: operand conditioning plus bit and group P/G terms.
    always_comb begin
        bb_s = {WIDTH{1'b0}};
        c0_d = 1'b0;
        if (sub) begin
            bb_s = ~b;
            c0_d = 1'b1;
        end else begin
            bb_s = b;
            c0_d = cin;
        end
        p_d  = a ^ bb_s;
        g_d  = a & bb_s;
        gp_d = {NG{1'b1}};
        gg_d = {NG{1'b0}};
        // Walking bottom-up folds g[top] | p[top]&(...) into one accumulator per group.
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GROUP; j++) begin
                gg_d[k] = g_d[k*GROUP+j] | (p_d[k*GROUP+j] & gg_d[k]);
                gp_d[k] = gp_d[k] & p_d[k*GROUP+j];
            end
        end
    end

    // Stage 2 combinational: group carries, in-group ripple, sum and flags.
    always_comb begin
        cg_s    = {(NG+1){1'b0}};
        c_s     = {(WIDTH+1){1'b0}};
        cg_s[0] = c0_q;
        for (int k = 0; k < NG; k++) begin
            cg_s[k+1] = gg_q[k] | (gp_q[k] & cg_s[k]);
        end
        for (int k = 0; k < NG; k++) begin
            c_s[k*GROUP] = cg_s[k];
            for (int j = 0; j < GROUP - 1; j++) begin
                c_s[k*GROUP+j+1] = g_q[k*GROUP+j] | (p_q[k*GROUP+j] & c_s[k*GROUP+j]);
            end
        end
        c_s[WIDTH] = cg_s[NG];
        sum_d  = p_q ^ c_s[WIDTH-1:0];
        cout_d = c_s[WIDTH];
        ovf_d  = c_s[WIDTH-1] ^ c_s[WIDTH];
    end

    // Stage 1 registers: load only on accept, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            p_q  <= {WIDTH{1'b0}};
            g_q  <= {WIDTH{1'b0}};
            gp_q <= {NG{1'b0}};
            gg_q <= {NG{1'b0}};
            c0_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            if (adv1_s) begin
                p_q  <= p_d;
                g_q  <= g_d;
                gp_q <= gp_d;
                gg_q <= gg_d;
                c0_q <= c0_d;
            end
        end
    end

    // Stage 2 registers: result is held stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q   <= 1'b0;
            sum_q  <= {WIDTH{1'b0}};
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            v2_q <= v2_d;
            if (adv2_s) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe: directed vector table, backpressure,
// mid-flight reset, and a randomized 32-bit / 8-bit-group stream against a reference sum.
module tb_cla_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic        out_valid, out_ready = 1'b1, cout, ovf;
    logic [15:0] a = 16'h0, b = 16'h0, sum;

    logic        in_valid_w = 1'b0, in_ready_w, cin_w = 1'b0, sub_w = 1'b0;
    logic        out_valid_w, out_ready_w = 1'b1, cout_w, ovf_w;
    logic [31:0] a_w = 32'h0, b_w = 32'h0, sum_w;

    cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    cla_adder_pipe #(.WIDTH(32), .GROUP(8)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .cin(cin_w), .sub(sub_w), .out_valid(out_valid_w),
        .out_ready(out_ready_w), .sum(sum_w), .cout(cout_w), .ovf(ovf_w)
    );

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sub;
        logic [15:0] sum;
        logic        cout, ovf;
    } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: {ovf, cout, sum} from plain integer addition of the conditioned operands.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] a_v, input logic [63:0] b_v,
                                            input logic cin_v, input logic sub_v);
        logic [63:0] mask, bb, s;
        logic [64:0] full;
        logic        c0, co, ov;
        mask = (64'd1 << w) - 64'd1;
        bb   = sub_v ? (~b_v & mask) : b_v;
        c0   = sub_v ? 1'b1 : cin_v;
        full = {1'b0, a_v} + {1'b0, bb} + {64'd0, c0};
        co   = full[w];
        s    = full[63:0] & mask;
        ov   = (a_v[w-1] == bb[w-1]) && (s[w-1] != a_v[w-1]);
        return {ov, co, s};
    endfunction

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bp_a[5], bp_b[5], stall_sum;
        logic        bp_sub[5];
        logic [65:0] exp_q[$];
        logic [65:0] wq[$];
        logic [65:0] r;
        int          nxt, got, issued, got_w;
        logic        acc_w;

        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[3]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[10] = '{16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{16'h8000, 16'h7FFF, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", out_valid, 0);
        chk("reset sum", sum, 0);
        chk("reset cout/ovf", {cout, ovf}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset in_ready", in_ready, 1);

        // Directed table, streamed back to back
        for (int t = 0; t < 14; t++) begin
            if (t >= 2) begin
                chk($sformatf("vec%0d valid", t-2), out_valid, 1);
                chk($sformatf("vec%0d sum", t-2), sum, vecs[t-2].sum);
                chk($sformatf("vec%0d cout", t-2), cout, vecs[t-2].cout);
                chk($sformatf("vec%0d ovf", t-2), ovf, vecs[t-2].ovf);
            end
            if (t < 12) begin
                in_valid = 1'b1; a = vecs[t].a; b = vecs[t].b;
                cin = vecs[t].cin; sub = vecs[t].sub;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("bubble after stream", out_valid, 0);

        // Backpressure: 5 ops, consumer stalled for 4 cycles
        bp_a = '{16'h7FF0, 16'h0101, 16'hFFFF, 16'h8000, 16'h1234};
        bp_b = '{16'h0020, 16'h0202, 16'h0001, 16'h0001, 16'h1234};
        bp_sub = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        nxt = 0; got = 0; stall_sum = 16'h0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            out_ready = (cyc >= 6);
            if (nxt < 5) begin
                in_valid = 1'b1; a = bp_a[nxt]; b = bp_b[nxt]; sub = bp_sub[nxt]; cin = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 2) begin
                chk("bp in_ready low", in_ready, 0);
                chk("bp accepts before stall", nxt, 2);
                stall_sum = sum;
            end
            if (cyc > 2 && cyc < 6) begin
                chk("bp sum hold", sum, stall_sum);
                chk("bp valid hold", out_valid, 1);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(16, {48'h0, a}, {48'h0, b}, cin, sub));
                nxt++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("bp spurious output", 1, 0);
                else chk($sformatf("bp result %0d", got), {ovf, cout, 48'h0, sum}, exp_q.pop_front());
                got++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp result count", got, 5);
        chk("bp queue empty", exp_q.size(), 0);

        // Reset mid-flight
        in_valid = 1'b1; a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'h2222; b = 16'h1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst pre valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst async valid", out_valid, 0);
        chk("rst async sum", sum, 0);
        chk("rst async flags", {cout, ovf}, 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("rst dropped op", out_valid, 0);
        in_valid = 1'b1; a = 16'h7FFF; b = 16'h7FFF; cin = 1'b1; sub = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst post latency1", out_valid, 0);
        @(posedge clk); #1;
        chk("rst post latency2", out_valid, 1);
        chk("rst post result", {ovf, cout, sum}, {1'b1, 1'b0, 16'hFFFF});
        @(posedge clk); #1;
        chk("rst post bubble", out_valid, 0);

        // Random stream on the 32-bit / 8-bit-group instance
        issued = 0; got_w = 0; acc_w = 1'b0;
        for (int cyc = 0; cyc < 40000 && got_w < 10000; cyc++) begin
            if (acc_w) in_valid_w = 1'b0;
            acc_w = 1'b0;
            out_ready_w = ($urandom_range(0, 3) != 0);
            if (!in_valid_w && issued < 10000 && $urandom_range(0, 3) != 0) begin
                in_valid_w = 1'b1;
                a_w = $urandom; b_w = $urandom;
                cin_w = 1'($urandom_range(0, 1)); sub_w = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) b_w = ~a_w;
                if ($urandom_range(0, 7) == 0) a_w = 32'hFFFF_FFFF;
            end
            #1;
            if (in_valid_w && in_ready_w) begin
                wq.push_back(ref_add(32, {32'h0, a_w}, {32'h0, b_w}, cin_w, sub_w));
                issued++;
                acc_w = 1'b1;
            end
            if (out_valid_w && out_ready_w) begin
                if (wq.size() == 0) chk("rand spurious output", 1, 0);
                else begin
                    r = wq.pop_front();
                    chk($sformatf("rand op %0d", got_w), {ovf_w, cout_w, 32'h0, sum_w}, r);
                end
                got_w++;
            end
            @(posedge clk); #1;
        end
        in_valid_w = 1'b0;
        chk("rand result count", got_w, 10000);
        chk("rand queue empty", wq.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
